controlador_de_riego: RTL and testbench
=======================================

# controlador_de_riego

Irrigation valve controller for the water-treatment module. It periodically enables the ESP32 sensor link and captures a 4-bit turbidity reading on the ESP's ready strobe. It then drives the valve (LED) output for a turbidity-dependent time before starting the next cycle. It sits between the ESP32 interface pins and the valve driver, in the 25 MHz clock domain.

## Interface
- CLK_FREQ_HZ, 25_000_000, clock frequency; defines the 1 s tick.
- STARTUP_S, 1, ticks spent in IDLE after reset before the first ESP enable.
- COOLDOWN_S, 2, ticks between valve-off and the next ESP enable.
- TH_HIGH, 12, turbidez ≥ TH_HIGH is high turbidity.
- TH_MED, 8, TH_MED ≤ turbidez < TH_HIGH is medium turbidity.
- T_HIGH_S, 2, valve-on ticks for high turbidity.
- T_MED_S, 5, valve-on ticks for medium turbidity.
- T_LOW_S, 10, valve-on ticks for low turbidity.
- clk  in  1  system clock, 25 MHz.
- reset  in  1  asynchronous, active-high reset.
- turbidez  in  4  turbidity reading from the ESP32; stable while ready_from_esp is high.
- ready_from_esp  in  1  ESP32 data-valid strobe; asynchronous to clk.
- enable_esp  out  1  registered request for the ESP32 to send a reading.
- led_valvula  out  1  registered valve/LED drive.

All duration parameters must be ≥1. An elaboration-time check fails if any is 0.

## Operation
- FSM states: IDLE, ENABLE_ESP, DECIDE, VALVE_ON, COOLDOWN.
- IDLE: wait STARTUP_S ticks, then go to ENABLE_ESP.
- ENABLE_ESP: enable_esp=1. Wait for a rising edge of the synchronized ready_from_esp. On that edge, capture turbidez into a 4-bit register and go to DECIDE.
- DECIDE (1 cycle): compare the captured value with the thresholds as unsigned values. Load the duration counter with T_HIGH_S, T_MED_S or T_LOW_S. Go to VALVE_ON.
- VALVE_ON: led_valvula=1 until the duration counter expires, then go to COOLDOWN.
- COOLDOWN: wait COOLDOWN_S ticks, then go to ENABLE_ESP. The cycle repeats indefinitely.
- ready_from_esp passes through a 2-FF synchronizer followed by rising-edge detection.
- A ready that is held high, or arrives outside ENABLE_ESP, is ignored. A fresh low→high transition is required in ENABLE_ESP.
- Readings 12–15 are high, 8–11 are medium and 0–7 are low (defaults).
- The duration counter is wide enough for the largest duration parameter and saturates at 0.

## Timing
- Reset (async assert, sync deassert by design convention): state=IDLE, enable_esp=0, led_valvula=0, counters=0, captured turbidity=0.
- Reset asserted mid-operation returns to IDLE immediately, and both outputs drop asynchronously.
- Both outputs are registered, decoded from the next state, so they change on the clock edge at which the state changes.
- Tick: one pulse every CLK_FREQ_HZ cycles. The prescaler is cleared on entry to every timed state, so N ticks last exactly N×CLK_FREQ_HZ cycles.
- ready edge to enable_esp low: 3 clk (2 sync + 1 edge-detect/capture).
- turbidez must be stable from the ready rise until 3 clk after it.
- Capture to led_valvula high: 2 clk (capture → DECIDE → VALVE_ON).
- led_valvula high time: exactly T_x_S ticks.
- led_valvula low to enable_esp high: exactly COOLDOWN_S ticks.

## Configuration
- CONTROLADOR_DE_RIEGO_SIM_TICK_EN defined: one tick = 10 clk, replacing CLK_FREQ_HZ, for simulation. All other behaviour is identical.
- Not defined: one tick = CLK_FREQ_HZ clk, i.e. 1 s.

## Structure
- Package controlador_de_riego_pkg holds the FSM state enum, the default thresholds/durations, and the sim tick length (10).
- Sub-module riego_tick_gen is the prescaler with a synchronous clear, emitting a 1-cycle tick pulse.
- The synchronizer, edge detector, FSM, capture register and duration counter stay in the top.

## Test plan
All scenarios run with CONTROLADOR_DE_RIEGO_SIM_TICK_EN defined.
- Reset held 4 clk, then released → both outputs 0 during reset; enable_esp rises 10 clk after release (STARTUP_S=1).
- In ENABLE_ESP, turbidez=12 with ready pulsed for 2 clk → enable_esp low 3 clk after the ready rise; led_valvula high 2 clk later for exactly 20 clk.
- After the valve goes off → enable_esp high again exactly 20 clk later; turbidez=9 plus ready pulse → led_valvula high for 50 clk.
- turbidez=3 → led_valvula high for 100 clk.
- Boundaries: 11 → 50 clk; 7 → 100 clk; 15 → 20 clk.
- Ready held high from ENABLE_ESP entry → no capture until ready falls and rises again. Reset asserted during VALVE_ON → led_valvula 0 immediately; restart from IDLE.

Source files
------------

// File: rtl/controlador_de_riego_pkg.sv
// Shared types and defaults for the irrigation valve controller.
package controlador_de_riego_pkg;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    ENABLE_ESP = 3'd1,
    DECIDE     = 3'd2,
    VALVE_ON   = 3'd3,
    COOLDOWN   = 3'd4
  } state_t;

  localparam int unsigned CLK_FREQ_HZ_DEF = 32'd25_000_000;
  localparam int unsigned STARTUP_S_DEF   = 32'd1;
  localparam int unsigned COOLDOWN_S_DEF  = 32'd2;
  localparam int unsigned TH_HIGH_DEF     = 32'd12;
  localparam int unsigned TH_MED_DEF      = 32'd8;
  localparam int unsigned T_HIGH_S_DEF    = 32'd2;
  localparam int unsigned T_MED_S_DEF     = 32'd5;
  localparam int unsigned T_LOW_S_DEF     = 32'd10;
  localparam int unsigned SIM_TICK_CLKS   = 32'd10;

  // Bits needed to hold any value in 0..v (at least one).
  function automatic int unsigned bits_for(input int unsigned v);
    int unsigned w;
    w = $clog2(v + 32'd1);
    return (w < 32'd1) ? 32'd1 : w;
  endfunction

  function automatic int unsigned max2(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/controlador_de_riego_if.sv
// ESP32 link and valve drive bundle; master is the ESP/valve side, slave is the controller.
interface controlador_de_riego_if;
  logic [3:0] turbidez;
  logic       ready_from_esp;
  logic       enable_esp;
  logic       led_valvula;

  modport master (
    output turbidez,
    output ready_from_esp,
    input  enable_esp,
    input  led_valvula
  );

  modport slave (
    input  turbidez,
    input  ready_from_esp,
    output enable_esp,
    output led_valvula
  );
endinterface

// File: rtl/controlador_de_riego_tick_gen.sv
// Prescaler producing a one-cycle tick every PERIOD clocks; i_clr restarts the period.
module riego_tick_gen
  import controlador_de_riego_pkg::*;
#(
  parameter int unsigned PERIOD = 32'd10
) (
  input  logic clk,
  input  logic reset,
  input  logic i_clr,
  output logic o_tick
);
  localparam int unsigned W = bits_for(PERIOD - 32'd1);
  localparam logic [W-1:0] LAST = W'(PERIOD - 32'd1);

  logic [W-1:0] r_cnt;

  // Free-running period counter, restarted by i_clr.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (i_clr || (r_cnt == LAST)) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + W'(1);
    end
  end

  assign o_tick = (r_cnt == LAST);
endmodule

// File: rtl/controlador_de_riego.sv
// Irrigation valve controller: polls the ESP32 for turbidity and opens the valve for a graded time.
// Define CONTROLADOR_DE_RIEGO_SIM_TICK_EN to shorten the tick to SIM_TICK_CLKS clocks.
module controlador_de_riego
  import controlador_de_riego_pkg::*;
#(
  parameter int unsigned CLK_FREQ_HZ = CLK_FREQ_HZ_DEF,
  parameter int unsigned STARTUP_S   = STARTUP_S_DEF,
  parameter int unsigned COOLDOWN_S  = COOLDOWN_S_DEF,
  parameter int unsigned TH_HIGH     = TH_HIGH_DEF,
  parameter int unsigned TH_MED      = TH_MED_DEF,
  parameter int unsigned T_HIGH_S    = T_HIGH_S_DEF,
  parameter int unsigned T_MED_S     = T_MED_S_DEF,
  parameter int unsigned T_LOW_S     = T_LOW_S_DEF
) (
  input  logic                  clk,
  input  logic                  reset,
  controlador_de_riego_if.slave bus
);
`ifdef CONTROLADOR_DE_RIEGO_SIM_TICK_EN
  localparam int unsigned TICK_PERIOD = SIM_TICK_CLKS;
`else
  localparam int unsigned TICK_PERIOD = CLK_FREQ_HZ;
`endif

  if ((CLK_FREQ_HZ == 32'd0) || (STARTUP_S == 32'd0) || (COOLDOWN_S == 32'd0) ||
      (T_HIGH_S == 32'd0) || (T_MED_S == 32'd0) || (T_LOW_S == 32'd0)) begin : g_bad_param
    $error("controlador_de_riego: duration parameters must be >= 1");
  end

  localparam int unsigned WAIT_MAX = max2(STARTUP_S, COOLDOWN_S);
  localparam int unsigned DUR_MAX  = max2(T_HIGH_S, max2(T_MED_S, T_LOW_S));
  localparam int unsigned WAIT_W   = bits_for(WAIT_MAX - 32'd1);
  localparam int unsigned DUR_W    = bits_for(DUR_MAX);

  state_t            r_state;
  logic              r_sync1, r_sync2, r_sync3;
  logic              r_rise;
  logic [3:0]        r_turb;
  logic [WAIT_W-1:0] r_wait;
  logic [DUR_W-1:0]  r_dur;
  logic              r_enable;
  logic              r_led;

  logic              w_tick;
  logic              w_clr;
  logic              w_rise;
  logic              w_wait_done;
  logic              w_dur_done;
  logic [WAIT_W-1:0] w_wait_lim;
  logic [DUR_W-1:0]  w_dur_sel;

  assign w_rise      = r_sync2 & ~r_sync3;
  assign w_wait_lim  = (r_state == COOLDOWN) ? WAIT_W'(COOLDOWN_S - 32'd1)
                                             : WAIT_W'(STARTUP_S - 32'd1);
  assign w_wait_done = w_tick && (r_wait == w_wait_lim);
  assign w_dur_done  = w_tick && (r_dur <= DUR_W'(1));
  assign w_dur_sel   = (32'(r_turb) >= TH_HIGH) ? DUR_W'(T_HIGH_S) :
                       (32'(r_turb) >= TH_MED)  ? DUR_W'(T_MED_S)  : DUR_W'(T_LOW_S);

  // High in the cycle before any state change, so every state starts on a fresh tick period.
  assign w_clr = ((r_state == IDLE)       && w_wait_done) ||
                 ((r_state == ENABLE_ESP) && r_rise)      ||
                  (r_state == DECIDE)                     ||
                 ((r_state == VALVE_ON)   && w_dur_done)  ||
                 ((r_state == COOLDOWN)   && w_wait_done);

  riego_tick_gen #(.PERIOD(TICK_PERIOD)) u_tick (
    .clk    (clk),
    .reset  (reset),
    .i_clr  (w_clr),
    .o_tick (w_tick)
  );

  // Ready synchronizer, tick counter and main FSM with outputs registered alongside the state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= IDLE;
      r_sync1  <= 1'b0;
      r_sync2  <= 1'b0;
      r_sync3  <= 1'b0;
      r_rise   <= 1'b0;
      r_turb   <= 4'd0;
      r_wait   <= '0;
      r_dur    <= '0;
      r_enable <= 1'b0;
      r_led    <= 1'b0;
    end else begin
      r_sync1 <= bus.ready_from_esp;
      r_sync2 <= r_sync1;
      r_sync3 <= r_sync2;

      if (w_clr) begin
        r_wait <= '0;
      end else if (w_tick) begin
        r_wait <= r_wait + WAIT_W'(1);
      end else begin
        r_wait <= r_wait;
      end

      case (r_state)
        IDLE: begin
          r_rise <= 1'b0;
          r_led  <= 1'b0;
          if (w_wait_done) begin
            r_state  <= ENABLE_ESP;
            r_enable <= 1'b1;
          end else begin
            r_enable <= 1'b0;
          end
        end
        ENABLE_ESP: begin
          r_led <= 1'b0;
          // Capture cycle drops the request; the following cycle moves on to DECIDE.
          if (r_rise) begin
            r_rise   <= 1'b0;
            r_state  <= DECIDE;
            r_enable <= 1'b0;
          end else if (w_rise) begin
            r_rise   <= 1'b1;
            r_turb   <= bus.turbidez;
            r_enable <= 1'b0;
          end else begin
            r_enable <= 1'b1;
          end
        end
        DECIDE: begin
          r_rise   <= 1'b0;
          r_dur    <= w_dur_sel;
          r_state  <= VALVE_ON;
          r_enable <= 1'b0;
          r_led    <= 1'b1;
        end
        VALVE_ON: begin
          r_rise   <= 1'b0;
          r_enable <= 1'b0;
          if (w_dur_done) begin
            r_dur   <= '0;
            r_state <= COOLDOWN;
            r_led   <= 1'b0;
          end else if (w_tick) begin
            r_dur <= r_dur - DUR_W'(1);
            r_led <= 1'b1;
          end else begin
            r_led <= 1'b1;
          end
        end
        COOLDOWN: begin
          r_rise <= 1'b0;
          r_led  <= 1'b0;
          if (w_wait_done) begin
            r_state  <= ENABLE_ESP;
            r_enable <= 1'b1;
          end else begin
            r_enable <= 1'b0;
          end
        end
        default: begin
          r_rise   <= 1'b0;
          r_state  <= IDLE;
          r_enable <= 1'b0;
          r_led    <= 1'b0;
        end
      endcase
    end
  end

  assign bus.enable_esp  = r_enable;
  assign bus.led_valvula = r_led;
endmodule

// File: tb/tb_controlador_de_riego.sv
// Directed bench for controlador_de_riego with a 10-clock tick.
module tb_controlador_de_riego;
  logic clk = 1'b0;
  logic reset;

  controlador_de_riego_if bus();

  controlador_de_riego #(.CLK_FREQ_HZ(10)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] turb;
    int         high_clk;
    string      name;
  } vec_t;

  vec_t vecs[8];
  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic sig(input int sel);
    return (sel == 1) ? bus.led_valvula : bus.enable_esp;
  endfunction

  // Counts clock edges until the selected output (0 = enable, 1 = led) equals val.
  task automatic count_until(input int sel, input logic val, input int limit, output int n);
    n = 0;
    while ((sig(sel) !== val) && (n < limit)) begin
      step();
      n++;
    end
  endtask

  task automatic run_cycle(input logic [3:0] turb, input int exp_high, input string tag);
    int n;
    check({tag, " enable_before"}, int'(bus.enable_esp), 1);
    bus.turbidez       = turb;
    bus.ready_from_esp = 1'b1;
    n = 0;
    while ((bus.enable_esp === 1'b1) && (n < 20)) begin
      step();
      n++;
      if (n == 2) bus.ready_from_esp = 1'b0;
    end
    bus.ready_from_esp = 1'b0;
    check({tag, " ready_to_enable_low"}, n, 3);
    count_until(1, 1'b1, 10, n);
    check({tag, " enable_low_to_led"}, n, 2);
    count_until(1, 1'b0, 200, n);
    check({tag, " led_high_clk"}, n, exp_high);
    count_until(0, 1'b1, 100, n);
    check({tag, " cooldown_clk"}, n, 20);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    int n;
    int cnt;
    vecs[0] = '{4'd12, 20,  "t12"};
    vecs[1] = '{4'd9,  50,  "t9"};
    vecs[2] = '{4'd3,  100, "t3"};
    vecs[3] = '{4'd11, 50,  "t11"};
    vecs[4] = '{4'd7,  100, "t7"};
    vecs[5] = '{4'd15, 20,  "t15"};
    vecs[6] = '{4'd8,  50,  "t8"};
    vecs[7] = '{4'd0,  100, "t0"};

    reset              = 1'b1;
    bus.turbidez       = 4'd0;
    bus.ready_from_esp = 1'b0;
    for (int i = 0; i < 4; i++) step();
    check("reset enable", int'(bus.enable_esp), 0);
    check("reset led", int'(bus.led_valvula), 0);
    reset = 1'b0;
    count_until(0, 1'b1, 50, n);
    check("startup_clk", n, 10);
    check("startup led", int'(bus.led_valvula), 0);

    for (int i = 0; i < 8; i++) begin
      run_cycle(vecs[i].turb, vecs[i].high_clk, vecs[i].name);
    end

    // Ready rising outside ENABLE_ESP and held high across entry must be ignored.
    bus.turbidez       = 4'd15;
    bus.ready_from_esp = 1'b1;
    step();
    step();
    bus.ready_from_esp = 1'b0;
    count_until(1, 1'b1, 10, n);
    bus.turbidez       = 4'd3;
    bus.ready_from_esp = 1'b1;
    count_until(1, 1'b0, 200, n);
    check("held led_high_clk", n, 20);
    count_until(0, 1'b1, 100, n);
    check("held cooldown_clk", n, 20);
    cnt = 0;
    for (int i = 0; i < 30; i++) begin
      step();
      if (bus.enable_esp === 1'b1) cnt++;
    end
    check("held no_capture", cnt, 30);
    check("held led_off", int'(bus.led_valvula), 0);
    bus.ready_from_esp = 1'b0;
    bus.turbidez       = 4'd12;
    for (int i = 0; i < 4; i++) step();
    run_cycle(4'd12, 20, "fresh");

    // Reset in the middle of VALVE_ON.
    bus.turbidez       = 4'd3;
    bus.ready_from_esp = 1'b1;
    step();
    step();
    bus.ready_from_esp = 1'b0;
    count_until(1, 1'b1, 20, n);
    check("mid led_on", int'(bus.led_valvula), 1);
    for (int i = 0; i < 5; i++) step();
    #2;
    reset = 1'b1;
    #1;
    check("async led_drop", int'(bus.led_valvula), 0);
    check("async enable_drop", int'(bus.enable_esp), 0);
    step();
    step();
    reset = 1'b0;
    count_until(0, 1'b1, 50, n);
    check("restart_clk", n, 10);
    check("restart led", int'(bus.led_valvula), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
